// File: rtl/icache_mshr_prefetch.sv
// Non-blocking icache miss controller: up to NUM_MSHR tagged loads in flight,
// demand misses from any fetch slot and a next-N-line prefetcher behind each.
module icache_mshr_prefetch #(
  parameter int FETCH_WIDTH    = 3,
  parameter int NUM_MSHR       = 4,
  parameter int PREFETCH_DEPTH = 2,
  parameter int INDEX_BITS     = 5,
  parameter int TAG_BITS       = 8,
  parameter int XLEN           = 32
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              take_branch,
  input  logic                              d_request,
  input  logic [FETCH_WIDTH-1:0][XLEN-1:0] fetch_addr,
  input  logic [FETCH_WIDTH-1:0]            fetch_valid,
  input  logic [FETCH_WIDTH-1:0]            fetch_hit,
  input  logic [3:0]                        Imem2proc_response,
  input  logic [63:0]                       Imem2proc_data,
  input  logic [3:0]                        Imem2proc_tag,
  output logic [1:0]                        proc2Imem_command,
  output logic [XLEN-1:0]                   proc2Imem_addr,
  output logic                              wr_en,
  output logic [INDEX_BITS-1:0]             wr_index,
  output logic [TAG_BITS-1:0]               wr_tag,
  output logic [63:0]                       wr_data,
  output logic                              mshr_full
);

  localparam int BW  = XLEN - 3;
  localparam int PFW = $clog2(PREFETCH_DEPTH + 2);
  localparam int MIW = (NUM_MSHR > 1) ? $clog2(NUM_MSHR) : 1;

  localparam logic [1:0] BUS_NONE = 2'h0;
  localparam logic [1:0] BUS_LOAD = 2'h1;

  logic [NUM_MSHR-1:0] r_valid;
  logic [NUM_MSHR-1:0] r_sq;
  logic [3:0]          r_mtag  [NUM_MSHR];
  logic [BW-1:0]       r_block [NUM_MSHR];
  logic [BW-1:0]       r_pf_next;
  logic [PFW-1:0]      r_pf_left;

  logic           w_dem_vld;
  logic [BW-1:0]  w_dem_blk;
  logic           w_dem_dup;
  logic           w_pf_vld;
  logic           w_pf_dup;
  logic           w_use_dem;
  logic           w_use_pf;
  logic           w_pf_skip;
  logic           w_issue;
  logic           w_accept;
  logic [BW-1:0]  w_req_blk;
  logic [MIW-1:0] w_free_idx;
  logic           w_ret_hit;
  logic [MIW-1:0] w_ret_idx;
  logic           w_unused;

  // Lowest missing slot wins; the loop runs high-to-low so slot 0 lands last.
  always_comb begin
    w_dem_vld = 1'b0;
    w_dem_blk = '0;
    for (int i = FETCH_WIDTH - 1; i >= 0; i--) begin
      if (fetch_valid[i] && !fetch_hit[i]) begin
        w_dem_vld = 1'b1;
        w_dem_blk = fetch_addr[i][XLEN-1:3];
      end
    end
  end

  always_comb begin
    w_dem_dup = 1'b0;
    w_pf_dup  = 1'b0;
    for (int e = 0; e < NUM_MSHR; e++) begin
      if (r_valid[e] && !r_sq[e]) begin
        if (r_block[e] == w_dem_blk) w_dem_dup = 1'b1;
        if (r_block[e] == r_pf_next) w_pf_dup = 1'b1;
      end
    end
  end

  always_comb begin
    w_unused = 1'b0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      w_unused = w_unused ^ (^fetch_addr[i][2:0]);
    end
  end

  assign mshr_full = &r_valid;
  assign w_pf_vld  = (r_pf_left != '0);
  assign w_use_dem = w_dem_vld && !w_dem_dup;
  assign w_use_pf  = !w_dem_vld && w_pf_vld && !w_pf_dup;
  assign w_pf_skip = !w_dem_vld && w_pf_vld && w_pf_dup;
  assign w_issue   = (w_use_dem || w_use_pf) && !d_request &&
                     !mshr_full && !take_branch;
  assign w_req_blk = w_use_dem ? w_dem_blk : r_pf_next;
  assign w_accept  = w_issue && (Imem2proc_response != 4'h0);

  assign proc2Imem_command = w_issue ? BUS_LOAD : BUS_NONE;
  assign proc2Imem_addr    = w_issue ? {w_req_blk, 3'b000} : '0;

  always_comb begin
    w_free_idx = '0;
    for (int e = NUM_MSHR - 1; e >= 0; e--) begin
      if (!r_valid[e]) w_free_idx = MIW'(e);
    end
  end

  always_comb begin
    w_ret_hit = 1'b0;
    w_ret_idx = '0;
    for (int e = 0; e < NUM_MSHR; e++) begin
      if (r_valid[e] && (Imem2proc_tag != 4'h0) &&
          (r_mtag[e] == Imem2proc_tag)) begin
        w_ret_hit = 1'b1;
        w_ret_idx = MIW'(e);
      end
    end
  end

  assign wr_en    = w_ret_hit && !r_sq[w_ret_idx];
  assign wr_index = wr_en ? r_block[w_ret_idx][INDEX_BITS-1:0] : '0;
  assign wr_tag   = wr_en ? r_block[w_ret_idx][INDEX_BITS +: TAG_BITS] : '0;
  assign wr_data  = wr_en ? Imem2proc_data : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_valid   <= '0;
      r_sq      <= '0;
      r_pf_next <= '0;
      r_pf_left <= '0;
      for (int e = 0; e < NUM_MSHR; e++) begin
        r_mtag[e]  <= '0;
        r_block[e] <= '0;
      end
    end else begin
      if (w_ret_hit) r_valid[w_ret_idx] <= 1'b0;
      if (take_branch) begin
        for (int e = 0; e < NUM_MSHR; e++) begin
          if (r_valid[e]) r_sq[e] <= 1'b1;
        end
      end
      // The free slot is always invalid, so it never collides with the return.
      if (w_accept) begin
        r_valid[w_free_idx] <= 1'b1;
        r_sq[w_free_idx]    <= 1'b0;
        r_mtag[w_free_idx]  <= Imem2proc_response;
        r_block[w_free_idx] <= w_req_blk;
      end
      if (take_branch) begin
        r_pf_left <= '0;
      end else if (w_accept && w_use_dem) begin
        r_pf_next <= w_dem_blk + 1'b1;
        r_pf_left <= PFW'(PREFETCH_DEPTH);
      end else if ((w_accept && w_use_pf) || w_pf_skip) begin
        r_pf_next <= r_pf_next + 1'b1;
        r_pf_left <= r_pf_left - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_icache_mshr_prefetch.sv
// Scoreboard bench: a queue-based model predicts each cycle's bus/write
// outputs; a monitor compares them against the DUT every cycle.
module tb_icache_mshr_prefetch;

  localparam int FW = 3;
  localparam int NM = 4;
  localparam int PD = 2;

  logic              clock = 1'b0;
  logic              reset;
  logic              take_branch;
  logic              d_request;
  logic [FW-1:0][31:0] fetch_addr;
  logic [FW-1:0]     fetch_valid;
  logic [FW-1:0]     fetch_hit;
  logic [3:0]        Imem2proc_response;
  logic [63:0]       Imem2proc_data;
  logic [3:0]        Imem2proc_tag;
  logic [1:0]        proc2Imem_command;
  logic [31:0]       proc2Imem_addr;
  logic              wr_en;
  logic [4:0]        wr_index;
  logic [7:0]        wr_tag;
  logic [63:0]       wr_data;
  logic              mshr_full;

  icache_mshr_prefetch #(
    .FETCH_WIDTH(FW), .NUM_MSHR(NM), .PREFETCH_DEPTH(PD),
    .INDEX_BITS(5), .TAG_BITS(8), .XLEN(32)
  ) dut (
    .clock(clock), .reset(reset),
    .take_branch(take_branch), .d_request(d_request),
    .fetch_addr(fetch_addr), .fetch_valid(fetch_valid),
    .fetch_hit(fetch_hit),
    .Imem2proc_response(Imem2proc_response),
    .Imem2proc_data(Imem2proc_data),
    .Imem2proc_tag(Imem2proc_tag),
    .proc2Imem_command(proc2Imem_command),
    .proc2Imem_addr(proc2Imem_addr),
    .wr_en(wr_en), .wr_index(wr_index), .wr_tag(wr_tag),
    .wr_data(wr_data), .mshr_full(mshr_full)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]  tag;
    logic [28:0] blk;
    bit          sq;
  } ent_t;

  typedef struct {
    logic [1:0]  cmd;
    logic [31:0] addr;
    logic        we;
    logic [4:0]  wi;
    logic [7:0]  wt;
    logic [63:0] wd;
    logic        full;
  } exp_t;

  ent_t        inflight[$];
  exp_t        expq[$];
  logic [28:0] pf_next;
  int          pf_left;
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic bit tag_busy(logic [3:0] t);
    foreach (inflight[k]) if (inflight[k].tag == t) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] free_tag();
    logic [3:0] t;
    do t = 4'($urandom_range(1, 15)); while (tag_busy(t));
    return t;
  endfunction

  // Reference model: predict this cycle's outputs, then advance one clock.
  task automatic step();
    exp_t        e;
    int          di;
    int          ri;
    logic [28:0] dblk;
    logic [28:0] rblk;
    logic [31:0] ra;
    bit          ddup, pdup, use_d, use_p, skip, iss, acc;
    e = '{cmd: 2'h0, addr: '0, we: 1'b0, wi: '0, wt: '0, wd: '0, full: 1'b0};
    if (reset) begin
      inflight.delete();
      pf_left = 0;
      pf_next = '0;
      expq.push_back(e);
      return;
    end
    di = -1;
    dblk = '0;
    for (int i = 0; i < FW; i++)
      if (di < 0 && fetch_valid[i] && !fetch_hit[i]) di = i;
    if (di >= 0) dblk = fetch_addr[di][31:3];
    ddup = 0;
    pdup = 0;
    foreach (inflight[k]) begin
      if (!inflight[k].sq && di >= 0 && inflight[k].blk == dblk) ddup = 1;
      if (!inflight[k].sq && inflight[k].blk == pf_next) pdup = 1;
    end
    use_d = (di >= 0) && !ddup;
    use_p = (di < 0) && pf_left > 0 && !pdup;
    skip  = (di < 0) && pf_left > 0 && pdup;
    e.full = (inflight.size() == NM);
    iss = (use_d || use_p) && !d_request && !e.full && !take_branch;
    rblk = use_d ? dblk : pf_next;
    if (iss) begin
      e.cmd  = 2'h1;
      e.addr = {rblk, 3'b000};
    end
    acc = iss && (Imem2proc_response != 0);
    ri = -1;
    if (Imem2proc_tag != 0)
      foreach (inflight[k]) if (inflight[k].tag == Imem2proc_tag) ri = k;
    if (ri >= 0 && !inflight[ri].sq) begin
      ra   = {inflight[ri].blk, 3'b000};
      e.we = 1'b1;
      e.wi = ra[7:3];
      e.wt = ra[15:8];
      e.wd = Imem2proc_data;
    end
    expq.push_back(e);
    if (ri >= 0) inflight.delete(ri);
    if (take_branch) begin
      foreach (inflight[k]) inflight[k].sq = 1'b1;
      pf_left = 0;
    end else if (acc) begin
      inflight.push_back('{tag: Imem2proc_response, blk: rblk, sq: 1'b0});
      if (use_d) begin
        pf_next = dblk + 29'd1;
        pf_left = PD;
      end else begin
        pf_next = pf_next + 29'd1;
        pf_left = pf_left - 1;
      end
    end else if (skip) begin
      pf_next = pf_next + 29'd1;
      pf_left = pf_left - 1;
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", nm, got, want);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    #2;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      n_cmp++;
      if (proc2Imem_command !== e.cmd || proc2Imem_addr !== e.addr ||
          wr_en !== e.we || wr_index !== e.wi || wr_tag !== e.wt ||
          wr_data !== e.wd || mshr_full !== e.full) begin
        n_bad++;
        $display("FAIL cycle t=%0t: got cmd=%0h addr=%h we=%0b idx=%0h tag=%0h data=%h full=%0b required cmd=%0h addr=%h we=%0b idx=%0h tag=%0h data=%h full=%0b",
          $time, proc2Imem_command, proc2Imem_addr, wr_en, wr_index,
          wr_tag, wr_data, mshr_full, e.cmd, e.addr, e.we, e.wi, e.wt,
          e.wd, e.full);
      end
    end
  end

  task automatic idle();
    reset = 0; take_branch = 0; d_request = 0;
    fetch_addr = '0; fetch_valid = '0; fetch_hit = '0;
    Imem2proc_response = 0; Imem2proc_data = '0; Imem2proc_tag = 0;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] base;
    base = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFE0 : 32'h0000_1000;
    return base + 32'($urandom_range(0, 7) * 8) + 32'($urandom_range(0, 7));
  endfunction

  initial begin
    idle();
    reset = 1;
    @(negedge clock);
    step(); #1;
    chk("rst_cmd", 64'(proc2Imem_command), 64'h0);
    chk("rst_addr", 64'(proc2Imem_addr), 64'h0);
    chk("rst_wr_en", 64'(wr_en), 64'h0);
    chk("rst_full", 64'(mshr_full), 64'h0);
    @(negedge clock);
    idle();
    fetch_valid = 3'b001; fetch_addr[0] = 32'h1000; Imem2proc_response = 1;
    step(); #1;
    chk("demand_addr", 64'(proc2Imem_addr), 64'h1000);
    chk("demand_cmd", 64'(proc2Imem_command), 64'h1);
    @(negedge clock);
    fetch_valid = 0; Imem2proc_response = 2;
    step(); #1;
    chk("pf1_addr", 64'(proc2Imem_addr), 64'h1008);
    @(negedge clock);
    Imem2proc_response = 3;
    step(); #1;
    chk("pf2_addr", 64'(proc2Imem_addr), 64'h1010);
    @(negedge clock);
    Imem2proc_response = 0;
    step(); #1;
    chk("pf_done_cmd", 64'(proc2Imem_command), 64'h0);
    @(negedge clock);
    Imem2proc_tag = 1; Imem2proc_data = 64'hDEAD;
    step(); #1;
    chk("ret_wr_en", 64'(wr_en), 64'h1);
    chk("ret_index", 64'(wr_index), 64'h0);
    chk("ret_tag", 64'(wr_tag), 64'h10);
    chk("ret_data", wr_data, 64'hDEAD);
    @(negedge clock);
    Imem2proc_tag = 0;
    fetch_valid = 3'b001; fetch_addr[0] = 32'h3000; Imem2proc_response = 4;
    step(); @(negedge clock);
    fetch_valid = 0; Imem2proc_response = 5;
    step(); @(negedge clock);
    fetch_valid = 3'b010; fetch_addr[1] = 32'h4000; Imem2proc_response = 6;
    step(); #1;
    chk("full_flag", 64'(mshr_full), 64'h1);
    chk("full_blocks", 64'(proc2Imem_command), 64'h0);
    @(negedge clock);
    Imem2proc_tag = 2;
    step(); #1;
    chk("full_ret_wr", 64'(wr_en), 64'h1);
    chk("full_same_cyc", 64'(proc2Imem_command), 64'h0);
    @(negedge clock);
    Imem2proc_tag = 0;
    step(); #1;
    chk("unblock_addr", 64'(proc2Imem_addr), 64'h4000);
    @(negedge clock);
    take_branch = 1; Imem2proc_response = 7; fetch_addr[1] = 32'h5000;
    step(); #1;
    chk("branch_cmd", 64'(proc2Imem_command), 64'h0);
    @(negedge clock);
    take_branch = 0; fetch_valid = 0; Imem2proc_response = 0;
    Imem2proc_tag = 3;
    step(); #1;
    chk("squash_wr", 64'(wr_en), 64'h0);
    @(negedge clock);

    for (int c = 0; c < 4000; c++) begin
      idle();
      if ($urandom_range(0, 299) == 0) begin
        reset = 1;
      end else begin
        take_branch = ($urandom_range(0, 15) == 0);
        d_request   = ($urandom_range(0, 4) == 0);
        for (int i = 0; i < FW; i++) begin
          fetch_addr[i]  = rand_addr();
          fetch_valid[i] = ($urandom_range(0, 2) == 0);
          fetch_hit[i]   = ($urandom_range(0, 1) == 0);
        end
        if ($urandom_range(0, 2) != 0) Imem2proc_response = free_tag();
        case ($urandom_range(0, 3))
          1, 2: if (inflight.size() > 0)
            Imem2proc_tag = inflight[$urandom_range(0, inflight.size() - 1)].tag;
          3: Imem2proc_tag = free_tag();
          default: Imem2proc_tag = 0;
        endcase
        Imem2proc_data = {$urandom, $urandom};
      end
      step();
      @(negedge clock);
    end
    idle();
    step();
    @(negedge clock);
    #3;
    n_cmp++;
    if (expq.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending required 0", expq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/icache_mshr_prefetch.md
# icache_mshr_prefetch

Non-blocking instruction-cache miss controller for the R10K fetch path, a parametrised successor to the single-miss icache controller. It tracks up to NUM_MSHR outstanding tagged memory loads. It issues demand misses for any of FETCH_WIDTH fetch slots, and runs a next-N-line sequential prefetcher behind each demand miss. It sits between the fetch stage / icache memory and the shared memory bus, and yields the bus to the dcache.

## Interface
- FETCH_WIDTH, 3, fetch slots examined per cycle
- NUM_MSHR, 4, outstanding load entries
- PREFETCH_DEPTH, 2, lines prefetched after each demand miss (0 disables)
- INDEX_BITS, 5, cache index width
- TAG_BITS, 8, cache tag width
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high; one clock
- take_branch  in  1  fetch redirect; squashes in-flight and prefetch state
- d_request  in  1  dcache owns bus this cycle
- fetch_addr  in  FETCH_WIDTH×XLEN  fetch slot addresses
- fetch_valid  in  FETCH_WIDTH  slot requests an instruction
- fetch_hit  in  FETCH_WIDTH  slot hit in cache memory
- Imem2proc_response  in  4  nonzero = load accepted with this tag
- Imem2proc_data  in  64  returned line
- Imem2proc_tag  in  4  nonzero = data valid for this tag
- proc2Imem_command  out  2  BUS_NONE / BUS_LOAD
- proc2Imem_addr  out  XLEN  8-byte-aligned line address
- wr_en  out  1  write returned line into cache memory
- wr_index  out  INDEX_BITS  write index
- wr_tag  out  TAG_BITS  write tag
- wr_data  out  64  write data
- mshr_full  out  1  all entries valid

## Operation
- Line block B = addr[XLEN-1:3]; index = addr[3 +: INDEX_BITS]; tag = addr[3+INDEX_BITS +: TAG_BITS].
- MSHR entry fields: valid, mem_tag[3:0], block, squashed.
- Live entry = valid and not squashed.
- Demand candidate: lowest slot i with fetch_valid[i] & !fetch_hit[i].
- Prefetch candidate: pf_next, when pf_left > 0.
- Priority: demand > prefetch.
- Demand duplicate (block equals any live entry block): no issue; demand holds; prefetch is not considered that cycle.
- Prefetch duplicate: no issue; pf_next++, pf_left-- (skip costs one cycle).
- Issue when !d_request, !mshr_full, !take_branch, and a non-duplicate candidate exists: proc2Imem_command=BUS_LOAD, proc2Imem_addr={B,3'b0}. Otherwise BUS_NONE, addr 0.
- Accept when Imem2proc_response≠0 during an issue. Allocate the lowest invalid entry with mem_tag=response, squashed=0.
  - Accepted demand: pf_next=B+1, pf_left=PREFETCH_DEPTH.
  - Accepted prefetch: pf_next++, pf_left--.
- Response 0: no state change; the same request is re-evaluated next cycle.
- Block arithmetic wraps modulo 2^(XLEN-3).
- Return: Imem2proc_tag≠0 matching a valid entry frees that entry.
  - If the entry is not squashed: wr_en=1, wr_index/wr_tag from entry block, wr_data=Imem2proc_data.
  - Squashed: entry freed, wr_en=0.
  - Unmatched tag: ignored.
- take_branch: all valid entries set squashed; pf_left=0; no issue that cycle.
- Same-cycle return and allocate: both happen. The free slot and mshr_full come from registered state, so a same-cycle free does not unblock issue.
- Same-cycle return and take_branch: returning entry is freed; no write for any entry whose squashed bit was already set; the returning entry itself writes if its squashed bit was 0.
- Two entries never share mem_tag; an accept whose tag matches a valid entry is an environment error.

## Timing
- Reset: all entries invalid, pf_left=0, proc2Imem_command=BUS_NONE, proc2Imem_addr=0, wr_en=0, wr_index/wr_tag/wr_data=0, mshr_full=0.
- Reset mid-operation discards all entries; later returns are unmatched and ignored.
- Miss to BUS_LOAD: 0 cycles; command is combinational from inputs and registered state.
- Allocation visible next cycle.
- Back-to-back accepted issues: one per cycle.
- Data return to wr_en: 0 cycles (combinational); entry free next cycle.
- Demand miss to first prefetch issue: 1 cycle after accept.

## Test plan
- Reset; slot0 addr 0x1000 valid, miss; response=1 → BUS_LOAD 0x1000 same cycle. Then response 2, 3 → prefetch 0x1008, 0x1010 on the next two cycles; then BUS_NONE. Tag 1 returns 0xDEAD → wr_en=1, index 0, tag 0x10, data 0xDEAD.
- NUM_MSHR=4; four accepted loads never returned → mshr_full=1, BUS_NONE despite a new miss. Return tag 2 → wr_en; the cycle after, the pending miss issues.
- Miss with d_request=1 for 3 cycles → BUS_NONE throughout. BUS_LOAD with the same addr on the cycle d_request drops.
- Response=0 for 2 cycles → proc2Imem_addr identical each cycle, no allocation; accepted on the third.
- Two loads in flight; take_branch=1 → BUS_NONE that cycle. Both tags return with wr_en=0 and entries freed; new miss 0x2000 issues the next cycle with prefetch 0x2008.
- Miss at 0x1000 in flight; slot1 misses same block → no second BUS_LOAD; prefetch of an in-flight block is skipped in one cycle.
